inv_cfg_sequencer: RTL and testbench
====================================

Name: inv_cfg_sequencer

Overview:
Owns the per-pin inversion configuration (INV_* bits) for a bank of NPINS invertible-pin cells. Accepts masked update requests over a valid/ready handshake and merges them into a shadow register. Serialises the shadow register onto a config scan chain, then commits it with an update strobe. Also provides a registered polarity-corrected data path (din XOR active inversion) so downstream logic sees the committed polarity.

Parameters:
NPINS, 8, number of invertible pins managed (1..32)
INIT_INV, {NPINS{1'b0}}, inversion pattern loaded into shadow and active registers at reset

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  update request valid
req_ready  output  1  sequencer can accept a request
req_inv  input  NPINS  requested inversion bits
req_mask  input  NPINS  1 = bit of req_inv applies to that pin
cfg_shift  output  1  scan-chain shift enable
cfg_sdo  output  1  scan-chain serial data, MSB first
cfg_update  output  1  one-cycle commit strobe to the cell bank
busy  output  1  sequence in progress (state != IDLE)
inv_active  output  NPINS  committed inversion pattern
din  input  NPINS  raw pin data
dout  output  NPINS  registered din ^ inv_active

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, shadow=INIT_INV, inv_active=INIT_INV, req_ready=1, busy=0, cfg_shift=0, cfg_sdo=0, cfg_update=0, dout=0, bit counter=0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, SHIFT, UPDATE.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready at edge T0: shadow <= (shadow & ~req_mask) | (req_inv & req_mask).
  - If req_mask != 0 -> SHIFT with counter=NPINS-1, and req_ready=0 from T0+1.
  - If req_mask == 0: request is consumed as a no-op. Stay in IDLE, req_ready stays 1, nothing on the chain.
- SHIFT:
  - Cycles T0+1 .. T0+NPINS: cfg_shift=1 and cfg_sdo=shadow[counter]. Counter decrements each cycle, giving MSB first.
  - After the cycle with counter==0 -> UPDATE.
  - shadow is frozen during SHIFT.
- UPDATE:
  - Cycle T0+NPINS+1: cfg_update=1, cfg_shift=0, cfg_sdo=0.
  - inv_active <= shadow at the end of that cycle.
  - -> IDLE; req_ready=1 and busy=0 from T0+NPINS+2.
- Throughput: one request per NPINS+2 cycles. Back-to-back requests are accepted on the first IDLE cycle.
- req_valid while req_ready=0 is ignored. The requester must hold req_valid/req_inv/req_mask stable until accepted.
- cfg_shift and cfg_update are never high in the same cycle. cfg_sdo is 0 whenever cfg_shift=0.
- Data path: dout <= din ^ inv_active every cycle, 1-cycle latency.
  - Polarity switches on the edge after cfg_update, and applies to all bits simultaneously.
  - No glitch mixing of old and new pattern within one dout word.
- Reset mid-sequence (rst_n low in SHIFT or UPDATE):
  - Immediate return to reset values.
  - No cfg_update is issued, and the partial chain content is left for the next full sequence to overwrite.
- NPINS=1: SHIFT lasts exactly one cycle.
- Counter width: clog2(NPINS), minimum 1 bit.

Test Plan:
- Reset with NPINS=8, INIT_INV=8'h00, din=8'hA5 -> after reset, dout=8'hA5 within 1 cycle, inv_active=8'h00, req_ready=1, cfg_* all 0.
- Request req_inv=8'hFF, req_mask=8'h0F, accepted at T0 -> cfg_shift high T0+1..T0+8 with cfg_sdo sequence 0,0,0,0,1,1,1,1; cfg_update high only at T0+9; inv_active=8'h0F and req_ready=1 at T0+10; with din=8'hA5, dout=8'hAA from T0+11.
- Second request req_inv=8'h00, req_mask=8'h03 issued while busy and held valid -> not accepted until IDLE; then inv_active=8'h0C; bits 7:2 unchanged.
- Request with req_mask=8'h00 -> single-cycle accept, no cfg_shift/cfg_update, req_ready stays 1, inv_active unchanged.
- Assert rst_n low at T0+4 during SHIFT -> outputs return to reset values asynchronously, no cfg_update pulse, inv_active=INIT_INV; a fresh request then completes normally.
- Build with NPINS=1, INIT_INV=1'b1 -> dout=~din after reset; request inv=0, mask=1 gives one shift cycle with cfg_sdo=0, cfg_update at T0+2, dout=din afterwards.

Source files
------------

// File: rtl/inv_cfg_sequencer_if.sv
// -----------------------------------------------------------------------------
// inv_cfg_sequencer_if
//
// Request channel of the inversion-configuration sequencer. A requester
// offers a masked inversion update with a valid/ready handshake; the
// sequencer accepts it on a rising clock edge where both are high.
//
//   req_valid  requester -> sequencer  update request valid
//   req_ready  sequencer -> requester  sequencer can accept a request
//   req_inv    requester -> sequencer  requested inversion bits
//   req_mask   requester -> sequencer  1 = bit of req_inv applies to that pin
//
// master: the requester side.   slave: the sequencer side.
// -----------------------------------------------------------------------------
interface inv_cfg_sequencer_if #(
    parameter int NPINS = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [NPINS-1:0] req_inv;
    logic [NPINS-1:0] req_mask;

    modport master (
        output req_valid,
        output req_inv,
        output req_mask,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_inv,
        input  req_mask,
        output req_ready
    );
endinterface

// File: rtl/inv_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// inv_cfg_sequencer
//
// Owns the per-pin inversion configuration of a bank of NPINS invertible pin
// cells. Masked update requests are merged into a shadow register, the shadow
// is shifted MSB first onto the configuration scan chain, and a one-cycle
// update strobe then commits it to the cell bank. The same committed pattern
// drives a registered polarity-corrected copy of the raw pin data.
//
// Ports:
//   clk         single clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   req         request channel (slave modport of inv_cfg_sequencer_if)
//   cfg_shift   scan-chain shift enable
//   cfg_sdo     scan-chain serial data, MSB first, 0 when not shifting
//   cfg_update  one-cycle commit strobe to the cell bank
//   busy        a sequence is in progress
//   inv_active  committed inversion pattern
//   din         raw pin data
//   dout        registered din ^ inv_active
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module inv_cfg_sequencer #(
    parameter int               NPINS    = 8,
    parameter logic [NPINS-1:0] INIT_INV = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    inv_cfg_sequencer_if.slave  req,
    output logic                cfg_shift,
    output logic                cfg_sdo,
    output logic                cfg_update,
    output logic                busy,
    output logic [NPINS-1:0]    inv_active,
    input  logic [NPINS-1:0]    din,
    output logic [NPINS-1:0]    dout
);

    localparam int              CW       = (NPINS > 1) ? $clog2(NPINS) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(NPINS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_UPDATE
    } state_e;

    state_e           state_q,      state_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic [NPINS-1:0] shadow_q,     shadow_d;
    logic [NPINS-1:0] inv_active_q, inv_active_d;
    logic             req_ready_q,  req_ready_d;
    logic             busy_q,       busy_d;
    logic             cfg_shift_q,  cfg_shift_d;
    logic             cfg_sdo_q,    cfg_sdo_d;
    logic             cfg_update_q, cfg_update_d;
    logic [NPINS-1:0] dout_q,       dout_d;

    logic             req_fire;

    // req_ready_q is high exactly in IDLE, so a fire is only possible there.
    assign req_fire = req.req_valid & req_ready_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples the values present before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shadow_q     <= INIT_INV;
            inv_active_q <= INIT_INV;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            cfg_shift_q  <= 1'b0;
            cfg_sdo_q    <= 1'b0;
            cfg_update_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            inv_active_q <= inv_active_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            cfg_shift_q  <= cfg_shift_d;
            cfg_sdo_q    <= cfg_sdo_d;
            cfg_update_q <= cfg_update_d;
            dout_q       <= dout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of a combinational block;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        inv_active_d = inv_active_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    shadow_d = (shadow_q & ~req.req_mask) | (req.req_inv & req.req_mask);
                    // An all-zero mask cannot change the shadow, so there is
                    // nothing to push to the chain: consume it and stay idle.
                    if (|req.req_mask) begin
                        state_d = ST_SHIFT;
                        cnt_d   = CNT_LAST;
                    end
                end
            end

            ST_SHIFT: begin
                // The shadow is frozen here; only the bit pointer moves.
                if (cnt_q == '0) begin
                    state_d = ST_UPDATE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            ST_UPDATE: begin
                inv_active_d = shadow_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    // Outputs are decoded from the *next* state so that the output flops line
    // up with state_q: while state_q is SHIFT with pointer cnt_q, cfg_sdo
    // already carries shadow[cnt_q].
    always_comb begin
        req_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        cfg_shift_d  = (state_d == ST_SHIFT);
        cfg_update_d = (state_d == ST_UPDATE);

        // Explicit compare-select instead of a variable index keeps the mux
        // well-defined for every NPINS, including 1 and non-powers of two.
        cfg_sdo_d = 1'b0;
        if (state_d == ST_SHIFT) begin
            for (int i = 0; i < NPINS; i++) begin
                if (cnt_d == CW'(i)) begin
                    cfg_sdo_d = shadow_d[i];
                end
            end
        end

        // Whole-word XOR with the committed pattern: a polarity change lands
        // on all bits of one dout word together.
        dout_d = din ^ inv_active_q;
    end

    assign req.req_ready = req_ready_q;
    assign busy          = busy_q;
    assign cfg_shift     = cfg_shift_q;
    assign cfg_sdo       = cfg_sdo_q;
    assign cfg_update    = cfg_update_q;
    assign inv_active    = inv_active_q;
    assign dout          = dout_q;

endmodule

// File: tb/tb_inv_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inv_cfg_sequencer
//
// Drives two sequencer instances: an 8-pin bank with INIT_INV=8'h00 and a
// 1-pin bank with INIT_INV=1'b1. Expected chain bits, committed patterns and
// dout words are pushed to queues when stimulus is applied and popped when the
// design is sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_inv_cfg_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inv_cfg_sequencer_if #(.NPINS(8)) rq8 ();
    inv_cfg_sequencer_if #(.NPINS(1)) rq1 ();

    logic       cfg_shift8, cfg_sdo8, cfg_update8, busy8;
    logic [7:0] inv_active8, din8, dout8;
    logic       cfg_shift1, cfg_sdo1, cfg_update1, busy1;
    logic [0:0] inv_active1, din1, dout1;

    inv_cfg_sequencer #(.NPINS(8), .INIT_INV(8'h00)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(rq8.slave),
        .cfg_shift(cfg_shift8), .cfg_sdo(cfg_sdo8), .cfg_update(cfg_update8),
        .busy(busy8), .inv_active(inv_active8), .din(din8), .dout(dout8)
    );

    inv_cfg_sequencer #(.NPINS(1), .INIT_INV(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(rq1.slave),
        .cfg_shift(cfg_shift1), .cfg_sdo(cfg_sdo1), .cfg_update(cfg_update1),
        .busy(busy1), .inv_active(inv_active1), .din(din1), .dout(dout1)
    );

    // Observation mux: which instance the current directed step talks to.
    logic        sel = 1'b0;
    logic        o_shift, o_sdo, o_update, o_ready, o_busy;
    logic [31:0] o_inv;
    assign o_shift  = sel ? cfg_shift1    : cfg_shift8;
    assign o_sdo    = sel ? cfg_sdo1      : cfg_sdo8;
    assign o_update = sel ? cfg_update1   : cfg_update8;
    assign o_ready  = sel ? rq1.req_ready : rq8.req_ready;
    assign o_busy   = sel ? busy1         : busy8;
    assign o_inv    = sel ? 32'(inv_active1) : 32'(inv_active8);

    int n_vec = 0;
    int n_bad = 0;
    bit din_rand = 1'b0;

    // Reference model state: index 0 = 8-pin bank, 1 = 1-pin bank.
    logic [31:0] m_sh  [2];
    logic [31:0] m_inv [2];
    localparam logic [31:0] INIT0 = 32'h0;
    localparam logic [31:0] INIT1 = 32'h1;

    // Scoreboards.
    logic [31:0] dq8 [$];
    logic [31:0] dq1 [$];
    logic [31:0] sq  [$];
    logic [31:0] iq  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [31:0] inv, input logic [31:0] mask);
        if (s == 0) begin
            rq8.req_valid = v;
            rq8.req_inv   = inv[7:0];
            rq8.req_mask  = mask[7:0];
        end else begin
            rq1.req_valid = v;
            rq1.req_inv   = inv[0:0];
            rq1.req_mask  = mask[0:0];
        end
    endtask

    // One clock: queue the dout each bank must show next cycle, cross the
    // rising edge, then compare on the falling edge.
    task automatic step();
        if (rst_n) begin
            dq8.push_back(32'(din8 ^ m_inv[0][7:0]));
            dq1.push_back(32'(din1 ^ m_inv[1][0:0]));
        end
        @(posedge clk);
        @(negedge clk);
        if (dq8.size() > 0) check("dout8", 32'(dout8), dq8.pop_front());
        if (dq1.size() > 0) check("dout1", 32'(dout1), dq1.pop_front());
        if (din_rand) begin
            din8 = 8'($urandom);
            din1 = 1'($urandom);
        end
    endtask

    // Issue one request to bank s and follow it through SHIFT/UPDATE/IDLE.
    // hold: keep req_valid high with (inv2, mask2) after acceptance.
    // abort_k: return at the negedge of cycle T0+abort_k (0 = never).
    task automatic do_req(input int s, input logic [31:0] inv, input logic [31:0] mask,
                          input bit hold, input logic [31:0] inv2, input logic [31:0] mask2,
                          input int abort_k);
        int          n;
        int          budget;
        logic [31:0] msk;
        logic [31:0] nsh;
        sel    = (s != 0);
        n      = (s != 0) ? 1 : 8;
        msk    = mask & ((s != 0) ? 32'h1 : 32'hFF);
        budget = 0;
        while (o_ready !== 1'b1 && budget < 40) begin
            step();
            budget++;
        end
        check("ready_wait", 32'(o_ready), 32'h1);
        drive(s, 1'b1, inv, mask);
        step();                                   // edge T0 accepts
        nsh     = (m_sh[s] & ~msk) | (inv & msk);
        m_sh[s] = nsh;
        if (hold) drive(s, 1'b1, inv2, mask2);
        else      drive(s, 1'b0, 32'h0, 32'h0);

        if (msk == 32'h0) begin
            for (int k = 1; k <= 2; k++) begin
                check("noop_ready",  32'(o_ready),  32'h1);
                check("noop_shift",  32'(o_shift),  32'h0);
                check("noop_update", 32'(o_update), 32'h0);
                check("noop_inv",    o_inv,         m_inv[s]);
                if (k < 2) step();
            end
            return;
        end

        for (int i = n - 1; i >= 0; i--) sq.push_back(32'(nsh[i]));
        iq.push_back(nsh);
        for (int k = 1; k <= n + 2; k++) begin
            if (k == abort_k) return;
            if (k <= n) begin
                check("shift",       32'(o_shift),  32'h1);
                check("sdo",         32'(o_sdo),    sq.pop_front());
                check("shift_upd",   32'(o_update), 32'h0);
                check("shift_ready", 32'(o_ready),  32'h0);
                check("shift_busy",  32'(o_busy),   32'h1);
            end else if (k == n + 1) begin
                check("upd_shift",   32'(o_shift),  32'h0);
                check("upd_sdo",     32'(o_sdo),    32'h0);
                check("upd_pulse",   32'(o_update), 32'h1);
                check("upd_inv_old", o_inv,         m_inv[s]);
            end else begin
                check("idle_ready",  32'(o_ready),  32'h1);
                check("idle_busy",   32'(o_busy),   32'h0);
                check("idle_update", 32'(o_update), 32'h0);
                m_inv[s] = iq.pop_front();
                check("inv_active",  o_inv,         m_inv[s]);
            end
            if (k < n + 2) step();
        end
    endtask

    task automatic check_reset_values();
        check("rst_shift8",  32'(cfg_shift8),    32'h0);
        check("rst_sdo8",    32'(cfg_sdo8),      32'h0);
        check("rst_update8", 32'(cfg_update8),   32'h0);
        check("rst_busy8",   32'(busy8),         32'h0);
        check("rst_ready8",  32'(rq8.req_ready), 32'h1);
        check("rst_inv8",    32'(inv_active8),   INIT0);
        check("rst_dout8",   32'(dout8),         32'h0);
        check("rst_inv1",    32'(inv_active1),   INIT1);
        check("rst_dout1",   32'(dout1),         32'h0);
    endtask

    initial begin
        m_sh[0] = INIT0; m_inv[0] = INIT0;
        m_sh[1] = INIT1; m_inv[1] = INIT1;
        drive(0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 32'h0);
        din8 = 8'hA5;
        din1 = 1'b0;

        // Reset state, then dout follows din within one cycle.
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        step();

        // 0x0F update, second request offered while busy and held.
        do_req(0, 32'hFF, 32'h0F, 1'b1, 32'h00, 32'h03, 0);
        // Accepted on the first IDLE cycle; only bits 1:0 change -> 0x0C.
        do_req(0, 32'h00, 32'h03, 1'b0, 32'h0, 32'h0, 0);
        // Zero mask is a single-cycle no-op.
        do_req(0, 32'h55, 32'h00, 1'b0, 32'h0, 32'h0, 0);

        // Random data and requests.
        din_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            do_req(0, $urandom, $urandom & 32'hFF, 1'b0, 32'h0, 32'h0, 0);
        end

        // Reset in the middle of SHIFT.
        do_req(0, 32'hA5, 32'hFF, 1'b0, 32'h0, 32'h0, 4);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        drive(0, 1'b0, 32'h0, 32'h0);
        sq.delete(); iq.delete(); dq8.delete(); dq1.delete();
        m_sh[0] = INIT0; m_inv[0] = INIT0;
        m_sh[1] = INIT1; m_inv[1] = INIT1;
        step();
        check("rst_no_update", 32'(cfg_update8), 32'h0);
        rst_n = 1'b1;
        step();
        check("post_rst_update", 32'(cfg_update8), 32'h0);
        // Fresh request merges into INIT, not into the aborted 0xA5.
        do_req(0, 32'h3C, 32'hF0, 1'b0, 32'h0, 32'h0, 0);

        // Single-pin bank: one shift cycle, then back and forth.
        do_req(1, 32'h0, 32'h1, 1'b0, 32'h0, 32'h0, 0);
        step();
        step();
        do_req(1, 32'h1, 32'h1, 1'b0, 32'h0, 32'h0, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
